// File: rtl/router_pkg.sv
// Shared constants, helper function and types for the N-output router
// synchroniser (router_sync_n) and its per-output timeout counters.
package router_pkg;

    localparam int ROUTER_NUM_PORTS = 3;
    localparam int ROUTER_ADDR_W    = 2;
    localparam int ROUTER_TIMEOUT   = 30;

    // Ceiling log2. clog2(TIMEOUT+1) gives the smallest CNT_W with 2**CNT_W > TIMEOUT.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Output-port index at the default address width.
    typedef logic [ROUTER_ADDR_W-1:0] port_idx_t;

endpackage

// File: rtl/router_sync_n_if.sv
// Bus between the router FSM/FIFO bank and router_sync_n.
//
// Handshake semantics: write_enb_reg is a write request that is qualified
// combinationally into the one-hot write_enb. There is no back-pressure
// on that path; the FSM uses fifo_full to stall itself. On the read side,
// vld_out[i] is valid and read_enb[i] is the consumer's ready/accept.
// Any cycle with valid=1 and ready=0 counts as a stall cycle.
interface router_sync_n_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2
);
    logic                 detect_add;
    logic [ADDR_W-1:0]    data_in;
    logic                 write_enb_reg;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] read_enb;
    logic [NUM_PORTS-1:0] vld_out;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] write_enb;
    logic [NUM_PORTS-1:0] soft_reset;
    logic                 addr_err;

    // Traffic side: the FSM, the FIFOs and the consumers.
    modport master (
        output detect_add, data_in, write_enb_reg, full, empty, read_enb,
        input  vld_out, fifo_full, write_enb, soft_reset, addr_err
    );

    // Router synchroniser side.
    modport slave (
        input  detect_add, data_in, write_enb_reg, full, empty, read_enb,
        output vld_out, fifo_full, write_enb, soft_reset, addr_err
    );
endinterface

// File: rtl/router_timeout_ctr.sv
// Stall-timeout counter for one router output. It pulses soft_reset for
// one cycle after TIMEOUT consecutive edges where the output holds data
// and the consumer does not read it.
module router_timeout_ctr #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             soft_reset_q, soft_reset_d;

    // Next state: count stalled edges, then wrap to 0 and fire on the last one.
    always_comb begin
        count_d      = '0;
        soft_reset_d = 1'b0;
        if (vld && !rd) begin
            if (count_q == LAST) begin
                count_d      = '0;
                soft_reset_d = 1'b1;
            end else begin
                count_d      = count_q + 1'b1;
            end
        end
    end

    // State register, cleared asynchronously.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q      <= '0;
            soft_reset_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            soft_reset_q <= soft_reset_d;
        end
    end

    assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_sync_n.sv
// router_sync_n: N-output router synchroniser. It latches the packet
// destination on header detect, steers the FIFO write enable, and muxes
// the full flag back. It also drives per-output valid and runs one stall
// timeout per output.
// Optional build macro ROUTER_SYNC_DEST_LOCK_EN: while write_enb_reg is high,
// detect_add is ignored, so an in-flight packet cannot be retargeted.
module router_sync_n
    import router_pkg::*;
#(
    parameter int NUM_PORTS = ROUTER_NUM_PORTS,
    parameter int ADDR_W    = ROUTER_ADDR_W,
    parameter int TIMEOUT   = ROUTER_TIMEOUT,
    parameter int CNT_W     = clog2(ROUTER_TIMEOUT + 1)
) (
    input  logic            clock,
    input  logic            resetn,
    router_sync_n_if.slave  bus
);

    // Compare addresses one bit wider than the field, so NUM_PORTS == 2**ADDR_W fits.
    localparam logic [ADDR_W:0] NP_CMP = (ADDR_W + 1)'(NUM_PORTS);

    logic [ADDR_W-1:0]    dest_q, dest_d;
    logic                 dest_ok_q, dest_ok_d;
    logic                 addr_err_q, addr_err_d;
    logic                 take_hdr;
    logic                 in_range;
    logic [NUM_PORTS-1:0] write_enb_w;
    logic                 fifo_full_w;
    logic [NUM_PORTS-1:0] soft_reset_w;

    assign in_range = ({1'b0, bus.data_in} < NP_CMP);

`ifdef ROUTER_SYNC_DEST_LOCK_EN
    assign take_hdr = bus.detect_add && !bus.write_enb_reg;
`else
    assign take_hdr = bus.detect_add;
`endif

    // Destination latch next state. addr_err is a pulse, low unless a header is taken.
    always_comb begin
        dest_d     = dest_q;
        dest_ok_d  = dest_ok_q;
        addr_err_d = 1'b0;
        if (take_hdr) begin
            dest_d     = bus.data_in;
            dest_ok_d  = in_range;
            addr_err_d = !in_range;
        end
    end

    // Destination registers, cleared asynchronously so a post-reset write goes nowhere.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dest_q     <= '0;
            dest_ok_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            dest_q     <= dest_d;
            dest_ok_q  <= dest_ok_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Zero-latency one-hot write steering and full-flag mux for the latched destination.
    always_comb begin
        write_enb_w = '0;
        fifo_full_w = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (dest_ok_q && (dest_q == ADDR_W'(i))) begin
                write_enb_w[i] = bus.write_enb_reg;
                fifo_full_w    = bus.full[i];
            end
        end
    end

    // One independent stall-timeout counter per output.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_tmo
        router_timeout_ctr #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_ctr (
            .clock      (clock),
            .resetn     (resetn),
            .vld        (!bus.empty[g]),
            .rd         (bus.read_enb[g]),
            .soft_reset (soft_reset_w[g])
        );
    end

    assign bus.vld_out    = ~bus.empty;
    assign bus.write_enb  = write_enb_w;
    assign bus.fifo_full  = fifo_full_w;
    assign bus.soft_reset = soft_reset_w;
    assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n (NUM_PORTS=3, ADDR_W=2, TIMEOUT=30).
module tb_router_sync_n;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    router_sync_n_if #(.NUM_PORTS(3), .ADDR_W(2)) bus ();

    router_sync_n #(
        .NUM_PORTS (3),
        .ADDR_W    (2),
        .TIMEOUT   (30),
        .CNT_W     (5)
    ) dut (
        .clock  (clk),
        .resetn (rst_n),
        .bus    (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] exp_sr;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.detect_add    = 1'b0;
        bus.data_in       = 2'd0;
        bus.write_enb_reg = 1'b0;
        bus.full          = 3'b000;
        bus.empty         = 3'b111;
        bus.read_enb      = 3'b000;
        #2;
        // Reset state
        bus.write_enb_reg = 1'b1;
        bus.full          = 3'b111;
        #1;
        check("rst_write_enb", 32'(bus.write_enb), 32'h0);
        check("rst_fifo_full", 32'(bus.fifo_full), 32'h0);
        check("rst_soft_reset", 32'(bus.soft_reset), 32'h0);
        check("rst_addr_err", 32'(bus.addr_err), 32'h0);
        check("rst_vld_out", 32'(bus.vld_out), 32'h0);
        bus.write_enb_reg = 1'b0;
        bus.full          = 3'b000;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Header to port 2, then 4 writes with port 2 full
        bus.data_in    = 2'd2;
        bus.detect_add = 1'b1;
        bus.full       = 3'b100;
        tick();
        bus.detect_add = 1'b0;
        check("hdr2_addr_err", 32'(bus.addr_err), 32'h0);
        bus.write_enb_reg = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("hdr2_write_enb", 32'(bus.write_enb), 32'h4);
            check("hdr2_fifo_full", 32'(bus.fifo_full), 32'h1);
            tick();
        end
        bus.write_enb_reg = 1'b0;
        #1;
        check("hdr2_idle_write_enb", 32'(bus.write_enb), 32'h0);

        // Invalid header address 3
        bus.data_in    = 2'd3;
        bus.detect_add = 1'b1;
        tick();
        bus.detect_add = 1'b0;
        check("bad_addr_err_pulse", 32'(bus.addr_err), 32'h1);
        bus.write_enb_reg = 1'b1;
        bus.full          = 3'b111;
        #1;
        check("bad_write_enb", 32'(bus.write_enb), 32'h0);
        check("bad_fifo_full", 32'(bus.fifo_full), 32'h0);
        tick();
        check("bad_addr_err_clear", 32'(bus.addr_err), 32'h0);
        check("bad_write_enb2", 32'(bus.write_enb), 32'h0);
        bus.write_enb_reg = 1'b0;
        bus.full          = 3'b000;

        // Header detected mid-packet
        bus.data_in    = 2'd1;
        bus.detect_add = 1'b1;
        tick();
        bus.detect_add    = 1'b0;
        bus.write_enb_reg = 1'b1;
        #1;
        check("lock_pre_write_enb", 32'(bus.write_enb), 32'h2);
        bus.data_in    = 2'd0;
        bus.detect_add = 1'b1;
        tick();
        bus.detect_add = 1'b0;
`ifdef ROUTER_SYNC_DEST_LOCK_EN
        check("lock_write_enb", 32'(bus.write_enb), 32'h2);
`else
        check("retarget_write_enb", 32'(bus.write_enb), 32'h1);
`endif
        check("retarget_addr_err", 32'(bus.addr_err), 32'h0);
        bus.write_enb_reg = 1'b0;

        // Channel 0 stalled for 60 edges
        bus.empty = 3'b110;
        #1;
        check("vld_out_ch0", 32'(bus.vld_out), 32'h1);
        for (int k = 1; k <= 60; k++) begin
            tick();
            exp_sr = (k == 30 || k == 60) ? 3'b001 : 3'b000;
            check($sformatf("stall60_k%0d", k), 32'(bus.soft_reset), 32'(exp_sr));
        end
        bus.empty = 3'b111;
        tick();
        check("stall60_after", 32'(bus.soft_reset), 32'h0);

        // 29 stalls, one read, 29 stalls: no timeout
        bus.empty = 3'b110;
        for (int k = 1; k <= 29; k++) begin
            tick();
            check("rd_a_soft_reset", 32'(bus.soft_reset), 32'h0);
        end
        bus.read_enb = 3'b001;
        tick();
        check("rd_mid_soft_reset", 32'(bus.soft_reset), 32'h0);
        bus.read_enb = 3'b000;
        for (int k = 1; k <= 29; k++) begin
            tick();
            check("rd_b_soft_reset", 32'(bus.soft_reset), 32'h0);
        end
        bus.empty = 3'b111;
        tick();
        check("rd_after_soft_reset", 32'(bus.soft_reset), 32'h0);

        // Channels 1 and 2 stalled, reset at cycle 15
        bus.empty = 3'b001;
        for (int k = 1; k <= 14; k++) begin
            tick();
            check("dual_pre_soft_reset", 32'(bus.soft_reset), 32'h0);
        end
        rst_n = 1'b0;
        bus.write_enb_reg = 1'b1;
        #1;
        check("midrst_soft_reset", 32'(bus.soft_reset), 32'h0);
        check("midrst_write_enb", 32'(bus.write_enb), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("postrst_write_enb", 32'(bus.write_enb), 32'h0);
        for (int k = 1; k <= 31; k++) begin
            tick();
            exp_sr = (k == 30) ? 3'b110 : 3'b000;
            check($sformatf("dual_k%0d", k), 32'(bus.soft_reset), 32'(exp_sr));
            if (k == 5) begin
                check("postrst_write_enb_k5", 32'(bus.write_enb), 32'h0);
            end
        end
        bus.write_enb_reg = 1'b0;
        bus.empty = 3'b111;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
